// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, horizontal and vertical
// region FSMs, and registered sync/blanking/coordinate outputs for one pixel.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_end,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last counter value of each region; the FSM leaves a region on that tick.
  localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

  localparam logic SYNC_ON = 1'(SYNC_POL);

  typedef enum logic [1:0] {ST_H_ACT, ST_H_FP, ST_H_SYNC, ST_H_BP} h_state_t;
  typedef enum logic [1:0] {ST_V_ACT, ST_V_FP, ST_V_SYNC, ST_V_BP} v_state_t;

  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  h_state_t   h_state_reg, h_state_next;
  v_state_t   v_state_reg, v_state_next;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      h_state_reg <= ST_H_ACT;
      v_state_reg <= ST_V_ACT;
    end else begin
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
      h_state_reg <= h_state_next;
      v_state_reg <= v_state_next;
    end
  end

  always_comb begin
    h_cnt_next   = h_cnt_reg;
    v_cnt_next   = v_cnt_reg;
    h_state_next = h_state_reg;
    v_state_next = v_state_reg;
    if (pix_en) begin
      h_cnt_next = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
      case (h_state_reg)
        ST_H_ACT:  if (h_cnt_reg == H_ACT_LAST)  h_state_next = ST_H_FP;
        ST_H_FP:   if (h_cnt_reg == H_FP_LAST)   h_state_next = ST_H_SYNC;
        ST_H_SYNC: if (h_cnt_reg == H_SYNC_LAST) h_state_next = ST_H_BP;
        ST_H_BP:   if (h_wrap)                   h_state_next = ST_H_ACT;
        default:                                 h_state_next = ST_H_ACT;
      endcase
      // The vertical side only moves on the horizontal wrap tick.
      if (h_wrap) begin
        v_cnt_next = v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
        case (v_state_reg)
          ST_V_ACT:  if (v_cnt_reg == V_ACT_LAST)  v_state_next = ST_V_FP;
          ST_V_FP:   if (v_cnt_reg == V_FP_LAST)   v_state_next = ST_V_SYNC;
          ST_V_SYNC: if (v_cnt_reg == V_SYNC_LAST) v_state_next = ST_V_BP;
          ST_V_BP:   if (v_wrap)                   v_state_next = ST_V_ACT;
          default:                                 v_state_next = ST_V_ACT;
        endcase
      end
    end
  end

  // Outputs sample the pre-increment counters/states, so every output
  // describes the same pixel, one tick behind the internal counters.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      video_on    <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        pixel_x     <= h_cnt_reg;
        pixel_y     <= v_cnt_reg;
        hsync       <= (h_state_reg == ST_H_SYNC) ? SYNC_ON : ~SYNC_ON;
        vsync       <= (v_state_reg == ST_V_SYNC) ? SYNC_ON : ~SYNC_ON;
        video_on    <= (h_state_reg == ST_H_ACT) && (v_state_reg == ST_V_ACT);
        line_end    <= h_wrap;
        frame_start <= (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced raster (25x11) with both sync polarities:
// hand-computed vectors, async-reset and stall sequences, random pix_en spacing.
module tb_vga_sync_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic pix_en = 1'b0;

  logic       hsync0, vsync0, video_on0, line_end0, frame_start0;
  logic [9:0] pixel_x0, pixel_y0;
  logic       hsync1, vsync1, video_on1, line_end1, frame_start1;
  logic [9:0] pixel_x1, pixel_y1;

  always #5 clk_in = ~clk_in;

  vga_sync_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)) dut0 (
    .clk_in(clk_in), .reset(reset), .pix_en(pix_en),
    .hsync(hsync0), .vsync(vsync0), .video_on(video_on0),
    .pixel_x(pixel_x0), .pixel_y(pixel_y0),
    .line_end(line_end0), .frame_start(frame_start0));

  vga_sync_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)) dut1 (
    .clk_in(clk_in), .reset(reset), .pix_en(pix_en),
    .hsync(hsync1), .vsync(vsync1), .video_on(video_on1),
    .pixel_x(pixel_x1), .pixel_y(pixel_y1),
    .line_end(line_end1), .frame_start(frame_start1));

  int tests = 0;
  int fails = 0;

  // Reference model: ticks since reset; pixel p = t-1 in raster order.
  int   t = 0;
  logic m_le = 1'b0, m_fs = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
    end
  endtask

  task automatic check_model();
    int p, x, y;
    logic hs_on, vs_on, vo;
    p = (t == 0) ? 0 : (t - 1);
    x = p % HT;
    y = (p / HT) % VT;
    hs_on = (t != 0) && (x >= HA + HF) && (x < HA + HF + HS);
    vs_on = (t != 0) && (y >= VA + VF) && (y < VA + VF + VS);
    vo    = (t != 0) && (x < HA) && (y < VA);
    chk("pixel_x", int'(pixel_x0), x);
    chk("pixel_y", int'(pixel_y0), y);
    chk("hsync_lo", int'(hsync0), int'(!hs_on));
    chk("vsync_lo", int'(vsync0), int'(!vs_on));
    chk("hsync_hi", int'(hsync1), int'(hs_on));
    chk("vsync_hi", int'(vsync1), int'(vs_on));
    chk("video_on", int'(video_on0), int'(vo));
    chk("line_end", int'(line_end0), int'(m_le));
    chk("frame_start", int'(frame_start0), int'(m_fs));
    chk("pol1_xy", int'({pixel_y1, pixel_x1}), int'({pixel_y0, pixel_x0}));
  endtask

  // One clock: drive at negedge, advance the model at posedge, settle #1.
  task automatic cycle(input logic en, input logic rst);
    int p;
    @(negedge clk_in);
    pix_en = en;
    reset  = rst;
    @(posedge clk_in);
    if (rst) begin
      t = 0; m_le = 0; m_fs = 0;
    end else if (en) begin
      t++;
      p = t - 1;
      m_le = ((p % HT) == HT - 1);
      m_fs = ((p % (HT * VT)) == 0);
    end else begin
      m_le = 0; m_fs = 0;
    end
    #1;
  endtask

  typedef struct {
    int         ticks;
    logic [9:0] x, y;
    logic       vo, hs, vs, le, fs;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // {ticks after reset, x, y, video_on, hsync(pol0), vsync(pol0), line_end, frame_start}
    vecs[0]  = '{1,   10'd0,  10'd0,  1, 1, 1, 0, 1};
    vecs[1]  = '{16,  10'd15, 10'd0,  1, 1, 1, 0, 0};
    vecs[2]  = '{17,  10'd16, 10'd0,  0, 1, 1, 0, 0};
    vecs[3]  = '{19,  10'd18, 10'd0,  0, 0, 1, 0, 0};
    vecs[4]  = '{21,  10'd20, 10'd0,  0, 0, 1, 0, 0};
    vecs[5]  = '{22,  10'd21, 10'd0,  0, 1, 1, 0, 0};
    vecs[6]  = '{25,  10'd24, 10'd0,  0, 1, 1, 1, 0};
    vecs[7]  = '{26,  10'd0,  10'd1,  1, 1, 1, 0, 0};
    vecs[8]  = '{151, 10'd0,  10'd6,  0, 1, 1, 0, 0};
    vecs[9]  = '{176, 10'd0,  10'd7,  0, 1, 0, 0, 0};
    vecs[10] = '{225, 10'd24, 10'd8,  0, 1, 0, 1, 0};
    vecs[11] = '{226, 10'd0,  10'd9,  0, 1, 1, 0, 0};
    vecs[12] = '{275, 10'd24, 10'd10, 0, 1, 1, 1, 0};
    vecs[13] = '{276, 10'd0,  10'd0,  1, 1, 1, 0, 1};

    // Reset state on both polarities.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("rst_x", int'(pixel_x0), 0);
    chk("rst_y", int'(pixel_y0), 0);
    chk("rst_video", int'(video_on0), 0);
    chk("rst_hs0", int'(hsync0), 1);
    chk("rst_vs0", int'(vsync0), 1);
    chk("rst_hs1", int'(hsync1), 0);
    chk("rst_vs1", int'(vsync1), 0);
    chk("rst_pulses", int'({line_end0, frame_start0}), 0);
    $display("[TB] reset state checked");

    // Table vectors: reset, then n back-to-back ticks, compare to constants.
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 1'b1);
      for (int k = 0; k < vecs[i].ticks; k++) cycle(1'b1, 1'b0);
      chk("vec_x", int'(pixel_x0), int'(vecs[i].x));
      chk("vec_y", int'(pixel_y0), int'(vecs[i].y));
      chk("vec_video", int'(video_on0), int'(vecs[i].vo));
      chk("vec_hs0", int'(hsync0), int'(vecs[i].hs));
      chk("vec_vs0", int'(vsync0), int'(vecs[i].vs));
      chk("vec_hs1", int'(hsync1), int'(!vecs[i].hs));
      chk("vec_vs1", int'(vsync1), int'(!vecs[i].vs));
      chk("vec_le", int'(line_end0), int'(vecs[i].le));
      chk("vec_fs", int'(frame_start0), int'(vecs[i].fs));
      $display("[TB] vec %0d ticks=%0d x=%0d y=%0d vo=%0b hs=%0b vs=%0b le=%0b fs=%0b",
               i, vecs[i].ticks, pixel_x0, pixel_y0, video_on0, hsync0, vsync0,
               line_end0, frame_start0);
    end

    // Pulse is one clk_in wide even when the next tick is far away.
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 25; k++) cycle(1'b1, 1'b0);
    chk("le_set", int'(line_end0), 1);
    cycle(1'b0, 1'b0);
    chk("le_clear", int'(line_end0), 0);
    chk("le_hold_x", int'(pixel_x0), 24);
    $display("[TB] line_end single-cycle pulse checked");

    // Stall: x frozen at 10 for 50 idle cycles, then advances to 11 with no pulses.
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 11; k++) cycle(1'b1, 1'b0);
    for (int k = 0; k < 50; k++) begin
      cycle(1'b0, 1'b0);
      check_model();
    end
    chk("stall_x", int'(pixel_x0), 10);
    cycle(1'b1, 1'b0);
    chk("stall_next_x", int'(pixel_x0), 11);
    chk("stall_pulses", int'({line_end0, frame_start0}), 0);
    $display("[TB] stall at x=10 checked");

    // Asynchronous reset mid-frame at (12,3): outputs clear before any edge.
    for (int k = 0; k < 3 * HT + 1; k++) cycle(1'b1, 1'b0);
    chk("pre_rst_xy", int'({pixel_y0, pixel_x0}), int'({10'd3, 10'd12}));
    @(negedge clk_in);
    #2 reset = 1'b1;
    #1;
    chk("async_x", int'(pixel_x0), 0);
    chk("async_y", int'(pixel_y0), 0);
    chk("async_video", int'(video_on0), 0);
    chk("async_hs0", int'(hsync0), 1);
    chk("async_hs1", int'(hsync1), 0);
    t = 0; m_le = 0; m_fs = 0;
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    chk("rel_xy", int'({pixel_y0, pixel_x0}), 0);
    chk("rel_fs", int'(frame_start0), 1);
    chk("rel_video", int'(video_on0), 1);
    $display("[TB] async reset mid-frame checked");

    // Random pix_en spacing with occasional resets, every cycle against the model.
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 4000; k++) begin
      cycle(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
            ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0);
      check_model();
    end
    $display("[TB] random phase done, model ticks=%0d", t);
    // Continuous pix_en over a full frame and a bit.
    for (int k = 0; k < HT * VT + 30; k++) begin
      cycle(1'b1, 1'b0);
      check_model();
    end
    $display("[TB] continuous phase done, model ticks=%0d", t);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA raster timing generator for the display interface. Runs on `clk_in` and advances one pixel per `pix_en` tick, where `pix_en` is the pixel-rate strobe from the VGA clock divider. Produces `hsync`/`vsync`, the active-video flag and the current pixel coordinates for the pixel pipeline. Defaults give 640x480 @ 60 Hz: 800 pixels per line, 525 lines per frame.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hsync`/`vsync`; 0 = active-low

Ports:
- `clk_in`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `pix_en`  in  1  pixel strobe, one `clk_in` cycle wide; all counting is qualified by it
- `hsync`  out  1  horizontal sync, polarity per `SYNC_POL`
- `vsync`  out  1  vertical sync, polarity per `SYNC_POL`
- `video_on`  out  1  1 while (`pixel_x`,`pixel_y`) lies inside the active area
- `pixel_x`  out  10  horizontal counter, 0..H_TOTAL-1
- `pixel_y`  out  10  vertical counter, 0..V_TOTAL-1
- `line_end`  out  1  one `clk_in` pulse: last pixel of a line has been output
- `frame_start`  out  1  one `clk_in` pulse: pixel (0,0) has been output

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters `h_cnt` and `v_cnt` are 10 bits wide.
  - On a `pix_en` tick, `h_cnt` increments.
  - At H_TOTAL-1 it wraps to 0 and `v_cnt` increments.
  - When `v_cnt` is at V_TOTAL-1 and `h_cnt` wraps, `v_cnt` also wraps to 0.
- Horizontal FSM states: H_ACT → H_FP → H_SYNC → H_BP → H_ACT. Transitions occur on the `pix_en` tick where `h_cnt` reaches the last pixel of the current region:
  - H_ACT exits at 639.
  - H_FP exits at 655.
  - H_SYNC exits at 751.
  - H_BP exits at 799.
- Vertical FSM states: V_ACT → V_FP → V_SYNC → V_BP → V_ACT. It advances only on the horizontal wrap tick, exiting at lines 479, 489, 491 and 524.
- Output decode:
  - `hsync` is asserted (=SYNC_POL) iff the H state is H_SYNC, i.e. x in 656..751.
  - `vsync` is asserted iff the V state is V_SYNC, i.e. y in 490..491.
  - `video_on` = (H state is H_ACT) AND (V state is V_ACT).
- All outputs are registered and mutually aligned: `pixel_x`, `pixel_y`, `hsync`, `vsync` and `video_on` always describe the same pixel.
- `pix_en` low: counters, FSMs and outputs hold. `line_end` and `frame_start` stay 0.

## Timing
- Reset (asynchronous, immediate):
  - `h_cnt` = 0, `v_cnt` = 0; FSMs in H_ACT / V_ACT.
  - `pixel_x` = 0, `pixel_y` = 0.
  - `hsync` = `vsync` = ~SYNC_POL; `video_on` = 0.
  - `line_end` = 0, `frame_start` = 0.
- Output latency: outputs update on the `clk_in` edge that samples `pix_en`=1, one tick behind the internal counters. The first `pix_en` after reset presents pixel (0,0) with `video_on`=1 and `frame_start`=1.
- `frame_start` and `line_end` are high for exactly one `clk_in` cycle, the cycle after the qualifying edge, regardless of `pix_en` spacing.
- Simultaneous events: at (799,524) `line_end` fires, and the following tick presents (0,0) with `frame_start`.
- `reset` asserted mid-frame: all state and outputs return to reset values at once. Counting resumes from (0,0) on the first `pix_en` after release.
- `pix_en` held high continuously is legal: one pixel per clock.
- Any `pix_en` spacing is legal; the timing in pixel ticks is unchanged.

## Test plan
- `pix_en` tied 1, reset released → `frame_start` at cycle 1; `line_end` pulses every 800 cycles; `frame_start` repeats every 420000 cycles.
- `pix_en` every 2nd cycle for 1 line → `hsync` low exactly 96 ticks starting at `pixel_x`=656; `video_on` high exactly 640 ticks, for x=0..639.
- Full frame → `vsync` low only while `pixel_y` is 490 or 491 (1600 ticks); `video_on` high for 307200 ticks; `pixel_y` wraps 524→0 as `pixel_x` wraps 799→0.
- Reset asserted at (300,200) with `pix_en` active → outputs immediately return to reset values; the first tick after release shows (0,0) with `frame_start`=1.
- `pix_en` held low for 50 cycles mid-line at x=100 → all outputs frozen at x=100; the next tick gives x=101 with no pulses.
- `SYNC_POL`=1 → `hsync`/`vsync` idle low and pulse high in the same windows.
